mdr_ctrl: RTL and testbench

Parametrised memory data register with a request/acknowledge read port, sub-word load extraction, sign/zero extension and a read timeout. Sits between the internal bus and the memory data interface in place of the fixed two-input MDR. Holds a value loaded from the bus for stores. Fetches, aligns and extends load data from memory over a variable-latency handshake.

---
 rtl/mdr_ctrl.sv | 122 ++++++++++++
 tb/tb_mdr_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mdr_ctrl.sv
// Memory data register: bus store path plus a request/acknowledge load path
// with sub-word extraction, sign/zero extension and a bounded wait for mem_ack.
module mdr_ctrl #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned OFFW    = $clog2(WIDTH / 8),
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             MDRin,
  input  logic             read,
  input  logic [1:0]       size,
  input  logic             sgn,
  input  logic [OFFW-1:0]  addr_lo,
  input  logic [WIDTH-1:0] busMuxOut,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_size;
  logic             r_sgn;
  logic [OFFW-1:0]  r_off;
  logic [WIDTH-1:0] r_q;
  logic             r_mem_req, r_done, r_err;

  logic             w_start, w_ack, w_tmo, w_load;
  logic [OFFW-1:0]  w_hoff;
  logic [WIDTH-1:0] w_bsh, w_hsh, w_ext;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_ack   = 1'b0;
    w_tmo   = 1'b0;
    w_load  = 1'b0;
    case (r_state)
      IDLE: begin
        if (read) begin
          w_start = 1'b1;
          w_next  = WAIT;
        end else if (MDRin) begin
          w_load = 1'b1;
        end
      end
      WAIT: begin
        // ack takes priority over a timeout landing on the same edge
        if (mem_ack) begin
          w_ack  = 1'b1;
          w_next = IDLE;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_tmo  = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Half loads reuse the byte shifter with the offset forced even.
  always_comb begin
    w_hoff    = r_off;
    w_hoff[0] = 1'b0;
    w_bsh     = mem_rdata >> {r_off, 3'b000};
    w_hsh     = mem_rdata >> {w_hoff, 3'b000};
    case (r_size)
      2'b00:   w_ext = {{(WIDTH-8){r_sgn & w_bsh[7]}}, w_bsh[7:0]};
      2'b01:   w_ext = {{(WIDTH-16){r_sgn & w_hsh[15]}}, w_hsh[15:0]};
      default: w_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_cnt     <= '0;
      r_size    <= '0;
      r_sgn     <= 1'b0;
      r_off     <= '0;
      r_q       <= '0;
      r_mem_req <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_mem_req <= (w_next == WAIT);
      r_done    <= w_ack | w_tmo;
      if (w_start) begin
        r_size <= size;
        r_sgn  <= sgn;
        r_off  <= addr_lo;
        r_cnt  <= '0;
        r_err  <= 1'b0;
      end else if (r_state == WAIT && !w_ack && !w_tmo) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_tmo) r_err <= 1'b1;
      if (w_ack)       r_q <= w_ext;
      else if (w_load) r_q <= busMuxOut;
    end
  end

  assign mem_req = r_mem_req;
  assign busy    = (r_state == WAIT);
  assign done    = r_done;
  assign err     = r_err;
  assign q       = r_q;

endmodule

// File: tb/tb_mdr_ctrl.sv
// Directed bench for mdr_ctrl: store path, sub-word loads, timeout, priorities
// and asynchronous clear during a read.
module tb_mdr_ctrl;

  logic        clk = 1'b0;
  logic        clr, MDRin, read, sgn, mem_ack;
  logic [1:0]  size;
  logic [1:0]  addr_lo;
  logic [31:0] busMuxOut, mem_rdata, q;
  logic        mem_req, busy, done, err;

  int checks = 0;
  int errors = 0;

  mdr_ctrl #(.WIDTH(32), .OFFW(2), .TIMEOUT(15)) dut (
    .clk(clk), .clr(clr), .MDRin(MDRin), .read(read), .size(size), .sgn(sgn),
    .addr_lo(addr_lo), .busMuxOut(busMuxOut), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .mem_req(mem_req), .q(q), .busy(busy), .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a read and return ack after 'delay' non-ack WAIT edges.
  task automatic do_read(input logic [1:0] sz, input logic sg, input logic [1:0] off,
                         input logic [31:0] data, input int delay);
    read = 1'b1; size = sz; sgn = sg; addr_lo = off;
    tick();
    read = 1'b0;
    repeat (delay) tick();
    mem_ack = 1'b1; mem_rdata = data;
    tick();
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1; MDRin = 1'b0; read = 1'b0; sgn = 1'b0; mem_ack = 1'b0;
    size = 2'b00; addr_lo = 2'd0; busMuxOut = '0; mem_rdata = '0;
    #3;
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL reset_q got %h exp %h", q, 32'h0); end
    checks++; if ({mem_req, busy, done, err} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {mem_req, busy, done, err}); end
    tick();
    clr = 1'b0;
    tick();
  endtask

  task automatic test_store();
    MDRin = 1'b1; busMuxOut = 32'hDEADBEEF;
    tick();
    MDRin = 1'b0;
    checks++; if (q !== 32'hDEADBEEF) begin errors++; $display("FAIL store_q got %h exp %h", q, 32'hDEADBEEF); end
  endtask

  task automatic test_byte_load();
    int nb = 0, nd = 0;
    read = 1'b1; size = 2'b00; sgn = 1'b1; addr_lo = 2'd2;
    tick();
    read = 1'b0;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL byte_req got %b exp 1", mem_req); end
    for (int i = 0; i < 2; i++) begin
      if (busy) nb++;
      if (done) nd++;
      tick();
    end
    mem_ack = 1'b1; mem_rdata = 32'h1280_3456;
    if (busy) nb++;
    if (done) nd++;
    tick();
    mem_ack = 1'b0;
    checks++; if (q !== 32'hFFFFFF80) begin errors++; $display("FAIL byte_q got %h exp %h", q, 32'hFFFFFF80); end
    checks++; if (nb != 3) begin errors++; $display("FAIL byte_busy_cycles got %0d exp 3", nb); end
    checks++; if ({done, busy, mem_req} !== 3'b100) begin errors++; $display("FAIL byte_done got %b exp 100", {done, busy, mem_req}); end
    tick();
    if (done) nd++;
    checks++; if (nd != 0 || done !== 1'b0) begin errors++; $display("FAIL byte_done_once got %0d/%b exp 0/0", nd, done); end
  endtask

  task automatic test_half_word();
    do_read(2'b01, 1'b0, 2'd3, 32'h8001_7FFF, 0);
    checks++; if (q !== 32'h00008001) begin errors++; $display("FAIL half_hi_zext got %h exp %h", q, 32'h00008001); end
    do_read(2'b01, 1'b1, 2'd0, 32'h8001_7FFF, 0);
    checks++; if (q !== 32'h00007FFF) begin errors++; $display("FAIL half_lo_sext got %h exp %h", q, 32'h00007FFF); end
    do_read(2'b10, 1'b1, 2'd1, 32'h8001_7FFF, 0);
    checks++; if (q !== 32'h80017FFF) begin errors++; $display("FAIL word_q got %h exp %h", q, 32'h80017FFF); end
    do_read(2'b00, 1'b0, 2'd3, 32'h8001_7FFF, 0);
    checks++; if (q !== 32'h00000080) begin errors++; $display("FAIL byte_zext got %h exp %h", q, 32'h00000080); end
    do_read(2'b11, 1'b1, 2'd2, 32'h8001_7FFF, 0);
    checks++; if (q !== 32'h80017FFF) begin errors++; $display("FAIL size11_q got %h exp %h", q, 32'h80017FFF); end
  endtask

  task automatic test_timeout();
    int nr = 0;
    read = 1'b1; size = 2'b10;
    tick();
    read = 1'b0;
    while (mem_req && nr < 40) begin
      nr++;
      tick();
    end
    checks++; if (nr != 15) begin errors++; $display("FAIL tmo_req_cycles got %0d exp 15", nr); end
    checks++; if ({done, err, busy} !== 3'b110) begin errors++; $display("FAIL tmo_flags got %b exp 110", {done, err, busy}); end
    checks++; if (q !== 32'h80017FFF) begin errors++; $display("FAIL tmo_q_kept got %h exp %h", q, 32'h80017FFF); end
    tick();
    checks++; if ({done, err} !== 2'b01) begin errors++; $display("FAIL tmo_err_sticky got %b exp 01", {done, err}); end
    read = 1'b1;
    tick();
    read = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL tmo_err_clear got %b exp 0", err); end
    mem_ack = 1'b1; mem_rdata = 32'h0000_00AB;
    tick();
    mem_ack = 1'b0;
    checks++; if (q !== 32'h000000AB) begin errors++; $display("FAIL tmo_next_q got %h exp %h", q, 32'h000000AB); end
  endtask

  task automatic test_simultaneous();
    read = 1'b1; MDRin = 1'b1; size = 2'b10; busMuxOut = 32'h1111_1111;
    tick();
    read = 1'b0; busMuxOut = 32'h2222_2222;
    checks++; if (q !== 32'h000000AB) begin errors++; $display("FAIL read_wins_q got %h exp %h", q, 32'h000000AB); end
    tick();
    checks++; if (q !== 32'h000000AB || busy !== 1'b1) begin errors++; $display("FAIL mdrin_wait_ignored got %h/%b exp %h/1", q, busy, 32'h000000AB); end
    repeat (13) tick();
    MDRin = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ack = 1'b0;
    checks++; if (q !== 32'hCAFEF00D) begin errors++; $display("FAIL ack_on_tmo_q got %h exp %h", q, 32'hCAFEF00D); end
    checks++; if ({done, err, busy} !== 3'b100) begin errors++; $display("FAIL ack_on_tmo_flags got %b exp 100", {done, err, busy}); end
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    tick();
    mem_ack = 1'b0;
    checks++; if (q !== 32'hCAFEF00D || done !== 1'b0) begin errors++; $display("FAIL idle_ack_ignored got %h/%b exp %h/0", q, done, 32'hCAFEF00D); end
  endtask

  task automatic test_reset_mid_read();
    int nd = 0;
    read = 1'b1; size = 2'b10;
    tick();
    read = 1'b0;
    #2 clr = 1'b1;
    #1;
    checks++; if ({mem_req, busy} !== 2'b00) begin errors++; $display("FAIL clr_mid_flags got %b exp 00", {mem_req, busy}); end
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL clr_mid_q got %h exp %h", q, 32'h0); end
    #2 clr = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    tick();
    if (done) nd++;
    mem_ack = 1'b0;
    tick();
    if (done) nd++;
    checks++; if (nd != 0 || q !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL clr_late_ack got done=%0d q=%h err=%b exp 0/%h/0", nd, q, err, 32'h0); end
  endtask

  initial begin
    test_reset();
    test_store();
    test_byte_load();
    test_half_word();
    test_timeout();
    test_simultaneous();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
